puf_tune_ctrl: RTL
==================

Name: puf_tune_ctrl

Overview:
- Sequencer and self-tuning controller for one PDL arbiter PUF unit (N_CB-bit challenge, N-bit tune, single-bit response).
- On start it latches a challenge, fires K evaluation pulses into the PUF, and counts the ones in the synchronised response.
- It then steps a thermometer-coded tune word until the response bias falls inside a balance window, for BIST/PUF characterisation.

Parameters:
N_CB, 64, challenge width of the PUF unit
N, 16, tune width; tune level range 0..N
K_LOG2, 7, evaluations per tuning step K = 2^K_LOG2
SETTLE, 8, cycles for each pulse phase (high and low); minimum 3
BAND, 8, half-width of the balance window around K/2
MAX_ITER, 32, maximum judge steps before fail

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; ignored while busy
challenge_in  input  N_CB  challenge latched on accepted start
busy  output  1  high from accepted start until done/fail asserts
done  output  1  sticky pass flag; cleared on next accepted start
fail  output  1  sticky fail flag; cleared on next accepted start
ones_count  output  K_LOG2+1  ones count from the most recent judged step
tune_level  output  $clog2(N+1)  current tune level
puf_in  output  1  evaluation edge driven to the PUF
puf_challenge  output  N_CB  registered challenge to the PUF
puf_tune  output  N  thermometer tune: bit i = (i < tune_level)
puf_out  input  1  raw arbiter response (asynchronous)

Behaviour:
- Reset is asynchronous. It drives state IDLE, all counters 0, and tune_level 0.
- Outputs at reset: busy=0, done=0, fail=0, ones_count=0, tune_level=0, puf_in=0, puf_challenge=0, puf_tune=0. All outputs are registered.
- puf_out passes through a 2-flop synchroniser; only the synchronised value is used.
- FSM states: IDLE, LOAD, HIGH, LOW, JUDGE.
- IDLE: on start, latch challenge_in into puf_challenge, set tune_level=N/2, clear done, fail, eval count, ones accumulator and iter count, set busy=1, go to LOAD.
- LOAD: 1 cycle for challenge/tune to settle, then go to HIGH.
- HIGH: puf_in=1 for exactly SETTLE cycles. In the last HIGH cycle, add the synchronised response to the ones accumulator and go to LOW.
- LOW: puf_in=0 for exactly SETTLE cycles. Then, if eval count == K-1, go to JUDGE; otherwise increment eval count and go to HIGH.
- Cycle accounting:
  - Evaluation period = 2*SETTLE cycles.
  - One step = 1 LOAD + K*2*SETTLE + 1 JUDGE cycles.
  - Default step = 2050 cycles.
- JUDGE (1 cycle):
  - Copy the accumulator (0..K, width K_LOG2+1) to ones_count and increment iter.
  - If ones ≤ K/2+BAND and ≥ K/2−BAND (inclusive, default 56..72): done=1, busy=0, go to IDLE. tune_level is held.
  - If ones > K/2+BAND: if tune_level==N, fail; else tune_level+1.
  - If ones < K/2−BAND: if tune_level==0, fail; else tune_level−1.
  - After an adjustment: if iter==MAX_ITER, fail; else clear the accumulator and eval count and go to LOAD.
  - Fail: fail=1, busy=0, go to IDLE. tune_level is held at its last value.
- Saturation check has priority over the MAX_ITER check; both report only fail.
- start while busy: ignored; no effect on the latched challenge.
- start in the same cycle that done/fail asserts: ignored (FSM not yet in IDLE).
- Reset mid-operation: immediate return to reset values; puf_in drops to 0 asynchronously.

Optional Feature:
- Macro PUF_TUNE_ITER_CNT_EN.
- Defined: adds output port iter_count [$clog2(MAX_ITER+1)-1:0]. It equals the number of JUDGE cycles executed since the last accepted start, resets to 0, and holds after done/fail.
- Undefined: the port is absent. The internal iter counter still exists for the MAX_ITER limit, and behaviour is otherwise identical.

Test Plan:
- Model puf_out toggling every evaluation (64 ones) → after start: exactly 128 puf_in pulses, each high 8 cycles; then done=1, fail=0, ones_count=64, tune_level=8, puf_tune=16'h00FF, busy low 2050 cycles after start accepted.
- Model puf_out=1 constantly → tune_level steps 8→16 (8 adjustments), then fail=1 on the 9th judge with tune_level=16 and ones_count=128; iter_count=9 with PUF_TUNE_ITER_CNT_EN.
- Model puf_out=1 if tune_level<11, toggling at 11 → done=1 at tune_level=11, ones_count=64, 4 judge steps.
- Model puf_out=1 for tune_level<11, else 0 → oscillation between 10 and 11; fail=1 after exactly 32 judges, not saturation.
- Assert start repeatedly during busy with a different challenge_in → puf_challenge unchanged, single run completes normally.
- Assert rst during the 50th HIGH phase → puf_in=0, busy=0, tune_level=0, puf_tune=0 in the same cycle; a new start then runs a full fresh sequence.

Source files
------------

// File: rtl/puf_tune_ctrl.sv
// puf_tune_ctrl: sequencer and self-tuning controller for one PDL arbiter PUF.
// A start latches a challenge, fires K = 2^K_LOG2 evaluation pulses and counts
// the ones in the synchronised response. The thermometer tune word is then
// stepped until the ones count lands inside K/2 +/- BAND, or the run fails on
// tune saturation or after MAX_ITER judge steps.
// Optional feature: define PUF_TUNE_ITER_CNT_EN to expose the judge step
// counter on the iter_count output port.
module puf_tune_ctrl #(
   parameter int N_CB     = 64,
   parameter int N        = 16,
   parameter int K_LOG2   = 7,
   parameter int SETTLE   = 8,
   parameter int BAND     = 8,
   parameter int MAX_ITER = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [N_CB-1:0]              challenge_in,
   output logic                         busy,
   output logic                         done,
   output logic                         fail,
   output logic [K_LOG2:0]              ones_count,
   output logic [$clog2(N+1)-1:0]       tune_level,
   output logic                         puf_in,
   output logic [N_CB-1:0]              puf_challenge,
   output logic [N-1:0]                 puf_tune,
   input  logic                         puf_out
`ifdef PUF_TUNE_ITER_CNT_EN
   ,
   output logic [$clog2(MAX_ITER+1)-1:0] iter_count
`endif
);

   localparam int TW = $clog2(N+1);
   localparam int IW = $clog2(MAX_ITER+1);
   localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int K  = 1 << K_LOG2;

   localparam logic [PW-1:0]     PHASE_LAST = PW'(SETTLE - 1);
   localparam logic [K_LOG2-1:0] EVAL_LAST  = K_LOG2'(K - 1);
   localparam logic [K_LOG2:0]   HI_TH      = (K_LOG2+1)'(K/2 + BAND);
   localparam logic [K_LOG2:0]   LO_TH      = (K_LOG2+1)'(K/2 - BAND);
   localparam logic [TW-1:0]     TUNE_MAX   = TW'(N);
   localparam logic [TW-1:0]     TUNE_MID   = TW'(N/2);
   localparam logic [IW-1:0]     ITER_LIMIT = IW'(MAX_ITER);

   typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, JUDGE} state_t;

   state_t              state, state_nxt;
   logic [PW-1:0]       phase, phase_nxt;
   logic [K_LOG2-1:0]   eval_cnt, eval_nxt;
   logic [K_LOG2:0]     acc, acc_nxt;
   logic [IW-1:0]       iter, iter_nxt;
   logic                busy_nxt, done_nxt, fail_nxt, puf_in_nxt;
   logic [K_LOG2:0]     ones_nxt;
   logic [TW-1:0]       tune_nxt;
   logic [N_CB-1:0]     chal_nxt;
   logic [N-1:0]        puf_tune_nxt;
   logic                saturated;
   logic                sync1, sync2;

   // Two-flop synchroniser for the asynchronous arbiter response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= puf_out;
         sync2 <= sync1;
      end
   end

   // State register; every output is a flop loaded from its next value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         phase         <= '0;
         eval_cnt      <= '0;
         acc           <= '0;
         iter          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         fail          <= 1'b0;
         ones_count    <= '0;
         tune_level    <= '0;
         puf_in        <= 1'b0;
         puf_challenge <= '0;
         puf_tune      <= '0;
      end else begin
         state         <= state_nxt;
         phase         <= phase_nxt;
         eval_cnt      <= eval_nxt;
         acc           <= acc_nxt;
         iter          <= iter_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         fail          <= fail_nxt;
         ones_count    <= ones_nxt;
         tune_level    <= tune_nxt;
         puf_in        <= puf_in_nxt;
         puf_challenge <= chal_nxt;
         puf_tune      <= puf_tune_nxt;
      end
   end

   // Next-state logic: pulse sequencing, ones accumulation and tune judgement
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      eval_nxt  = eval_cnt;
      acc_nxt   = acc;
      iter_nxt  = iter;
      busy_nxt  = busy;
      done_nxt  = done;
      fail_nxt  = fail;
      ones_nxt  = ones_count;
      tune_nxt  = tune_level;
      chal_nxt  = puf_challenge;
      saturated = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               chal_nxt  = challenge_in;
               tune_nxt  = TUNE_MID;
               done_nxt  = 1'b0;
               fail_nxt  = 1'b0;
               eval_nxt  = '0;
               acc_nxt   = '0;
               iter_nxt  = '0;
               phase_nxt = '0;
               busy_nxt  = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            phase_nxt = '0;
            state_nxt = HIGH;
         end
         HIGH: begin
            if (phase == PHASE_LAST) begin
               phase_nxt = '0;
               acc_nxt   = acc + (K_LOG2+1)'(sync2);
               state_nxt = LOW;
            end else begin
               phase_nxt = phase + PW'(1);
            end
         end
         LOW: begin
            if (phase == PHASE_LAST) begin
               phase_nxt = '0;
               if (eval_cnt == EVAL_LAST) begin
                  state_nxt = JUDGE;
               end else begin
                  eval_nxt  = eval_cnt + K_LOG2'(1);
                  state_nxt = HIGH;
               end
            end else begin
               phase_nxt = phase + PW'(1);
            end
         end
         JUDGE: begin
            ones_nxt = acc;
            iter_nxt = iter + IW'(1);
            if ((acc <= HI_TH) && (acc >= LO_TH)) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               if (acc > HI_TH) begin
                  if (tune_level == TUNE_MAX) saturated = 1'b1;
                  else tune_nxt = tune_level + TW'(1);
               end else begin
                  if (tune_level == '0) saturated = 1'b1;
                  else tune_nxt = tune_level - TW'(1);
               end
               if (saturated || (iter_nxt == ITER_LIMIT)) begin
                  fail_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  acc_nxt   = '0;
                  eval_nxt  = '0;
                  state_nxt = LOAD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Derived registered outputs: evaluation edge and thermometer tune word
   always_comb begin
      puf_in_nxt   = (state_nxt == HIGH);
      puf_tune_nxt = '0;
      for (int i = 0; i < N; i++) begin
         puf_tune_nxt[i] = (i < int'(tune_nxt));
      end
   end

`ifdef PUF_TUNE_ITER_CNT_EN
   assign iter_count = iter;
`endif

endmodule
